loop_sram_reader: RTL and testbench
===================================

// Module: loop_sram_reader
// PURPOSE
//  Playback end of the looper: reads the recorded loop back out of SRAM one sample per sample strobe.
//  The loop writer fills SRAM from address 0 and reports its sample count.
//  This block walks 0..len-1 cyclically through an SRAM arbiter and delivers each sample to the effect chain.
//  It sits between the SRAM arbiter and the DAC-side effect path and is active in the loop-play state.
// PARAMETERS
//  ADDR_W     20  SRAM word address width
//  DATA_W     16  signed sample width
//  READ_WAIT  2   cycles from grant to i_sram_rdata valid (async SRAM access time), >=1
// PORTS
//  i_clk         in   1       audio bit clock; all logic on posedge
//  i_rst_n       in   1       asynchronous, active-low reset
//  i_start       in   1       1-cycle pulse: start/restart playback at address 0
//  i_stop        in   1       1-cycle pulse: stop playback
//  i_loop_len    in   ADDR_W  recorded sample count; 0 = empty loop
//  i_valid       in   1       1-cycle sample strobe (DACLRCK rising edge)
//  i_live        in   DATA_W  signed live sample, used only with LOOP_MIX_EN
//  o_sram_req    out  1       read request to arbiter
//  i_sram_gnt    in   1       arbiter grant
//  o_sram_addr   out  ADDR_W  read address, stable while o_sram_req=1
//  i_sram_rdata  in   DATA_W  SRAM read data
//  o_data        out  DATA_W  signed output sample, held between o_valid pulses
//  o_valid       out  1       1-cycle pulse: new o_data
//  o_playing     out  1       high in any non-IDLE state
//  o_wrap        out  1       1-cycle pulse when the last loop sample is output
//  o_underrun    out  1       1-cycle pulse: i_valid arrived while a fetch was in flight
// BEHAVIOUR
//  Reset: state IDLE, rd_ptr=0, len_r=0, wait_cnt=0; every output 0.
//  States:
//   IDLE   -> ARMED on i_start with i_loop_len!=0; latch len_r=i_loop_len and rd_ptr=0.
//             i_start with i_loop_len==0 is ignored.
//   ARMED  -> REQ on i_valid.
//   REQ    -> o_sram_req=1, o_sram_addr=rd_ptr; -> READ on i_sram_gnt.
//             Load wait_cnt=READ_WAIT-1. Request is held until grant.
//   READ   -> count down; at wait_cnt==0 capture i_sram_rdata and form o_data, pulse o_valid next edge.
//             Advance rd_ptr (len_r-1 -> 0 with o_wrap pulse, coincident with o_valid); -> ARMED.
//  o_sram_req is deasserted in READ; the arbiter keeps the address path until its own release.
//  Latency: i_valid to o_valid = 1 + grant wait + READ_WAIT + 1 cycles; worst case fits one sample period.
//  i_valid in REQ/READ: o_underrun pulses; that strobe is dropped, never queued.
//  Stop wins over simultaneous start. i_stop in any state -> IDLE next cycle.
//   It drops o_sram_req immediately and discards the in-flight fetch (no o_valid).
//   o_data is cleared to 0 on entry to IDLE.
//  i_start while playing: restart at rd_ptr=0, re-latch len_r; abort any in-flight fetch as for stop.
//  i_loop_len changes during play are ignored until the next start.
//  len_r==1: every sample reads address 0 and pulses o_wrap.
//  Reset mid-fetch: request drops asynchronously; no partial output.
// CONFIGURATION
//  LOOP_MIX_EN defined:
//   o_data = sat(i_live_latched + loop_sample), saturating to [-32768, 32767].
//   i_live is latched on each i_valid.
//   In IDLE, each i_valid yields o_data=i_live and o_valid 1 cycle later (live pass-through).
//  LOOP_MIX_EN undefined:
//   o_data = loop sample verbatim; i_live unused.
//   In IDLE, o_valid never pulses.
// STRUCTURE
//  Package loop_pkg: state enum {IDLE, ARMED, REQ, READ}; default ADDR_W/DATA_W localparams;
//   function sat_add(DATA_W) shared with the loop writer's overdub path.
//  Sub-module loop_rd_ptr: wrap counter (clear, inc, len) -> ptr, wrap pulse; reused by the writer.
// TESTING
//  len=4, mem[0..3]={100,-200,300,-400}, gnt same cycle, start + 6 strobes
//   -> o_data 100,-200,300,-400,100,-200; o_wrap with -400.
//  start with i_loop_len=0 -> o_playing stays 0; no o_sram_req and no o_valid on any strobe.
//  gnt withheld 5 cycles, second i_valid during REQ
//   -> o_underrun pulses once; o_sram_addr stable; one o_valid only.
//  start and stop in the same cycle during READ
//   -> IDLE next cycle; o_sram_req=0, o_data=0, no o_valid.
//  MIX: live=30000, loop=10000 -> 32767; live=-30000, loop=-10000 -> -32768.
//   In IDLE, live=1234 -> o_data=1234.
//  restart (i_start) mid-loop at rd_ptr=2 with new len=2 -> next fetches addr 0,1,0; o_wrap at addr 1.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared looper types: playback FSM states, default bus widths and the saturating
// adder used by the mix path here and by the writer's overdub path.
package loop_pkg;

  localparam int LOOP_ADDR_W = 20;
  localparam int LOOP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    REQ   = 2'd2,
    READ  = 2'd3
  } loop_state_t;

  // Signed add clamped to the representable range instead of wrapping.
  function automatic logic signed [LOOP_DATA_W-1:0] sat_add(
    input logic signed [LOOP_DATA_W-1:0] a,
    input logic signed [LOOP_DATA_W-1:0] b
  );
    logic signed [LOOP_DATA_W:0] sum;
    sum = {a[LOOP_DATA_W-1], a} + {b[LOOP_DATA_W-1], b};
    if (sum[LOOP_DATA_W] != sum[LOOP_DATA_W-1]) begin
      return sum[LOOP_DATA_W] ? {1'b1, {(LOOP_DATA_W-1){1'b0}}}
                              : {1'b0, {(LOOP_DATA_W-1){1'b1}}};
    end
    return sum[LOOP_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/loop_sram_reader_if.sv
// Read port between the loop playback engine (master) and the SRAM arbiter (slave).
interface loop_sram_reader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // req is held with addr stable until gnt is seen high in the same cycle; that cycle
  // is the handshake. rdata is valid a fixed number of cycles after the handshake.
  logic                     req;
  logic                     gnt;
  logic [ADDR_W-1:0]        addr;
  logic signed [DATA_W-1:0] rdata;

  modport master (output req, addr, input gnt, rdata);
  modport slave  (input req, addr, output gnt, rdata);
endinterface

// File: rtl/loop_rd_ptr.sv
// Cyclic address counter 0..len-1; wrap is high in the cycle an increment rolls over to 0.
module loop_rd_ptr #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] len,
  output logic [W-1:0] ptr,
  output logic         wrap
);

  assign wrap = inc && (ptr == len - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= wrap ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/loop_sram_reader.sv
// Loop playback: fetches one recorded sample per strobe from SRAM, cycling 0..len-1.
// Optional LOOP_MIX_EN adds the latched live sample with saturation and passes live through in IDLE.
module loop_sram_reader
  import loop_pkg::*;
#(
  parameter int ADDR_W    = LOOP_ADDR_W,
  parameter int DATA_W    = LOOP_DATA_W,
  parameter int READ_WAIT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [ADDR_W-1:0]        i_loop_len,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_live,
  loop_sram_reader_if.master       sram,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_playing,
  output logic                     o_wrap,
  output logic                     o_underrun,
  output loop_state_t              o_state
);

  localparam int WC_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  loop_state_t              state, state_nxt;
  logic [ADDR_W-1:0]        len_r;
  logic [ADDR_W-1:0]        rd_ptr;
  logic [WC_W-1:0]          wait_cnt;
  logic                     ptr_clear, ptr_inc, ptr_wrap;
  logic                     len_load, wait_load, wait_dec, capture, clear_data;
  logic signed [DATA_W-1:0] sample;

  loop_rd_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (ptr_clear),
    .inc   (ptr_inc),
    .len   (len_r),
    .ptr   (rd_ptr),
    .wrap  (ptr_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Stop beats start; any start while playing aborts the fetch and rewinds.
  always_comb begin
    state_nxt  = state;
    ptr_clear  = 1'b0;
    ptr_inc    = 1'b0;
    len_load   = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    capture    = 1'b0;
    clear_data = 1'b0;
    if (i_stop) begin
      state_nxt  = IDLE;
      clear_data = 1'b1;
    end else if (i_start && (i_loop_len != '0)) begin
      state_nxt = ARMED;
      ptr_clear = 1'b1;
      len_load  = 1'b1;
    end else if (i_start && (state != IDLE)) begin
      state_nxt  = IDLE;
      clear_data = 1'b1;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        ARMED: if (i_valid) state_nxt = REQ;
        REQ: begin
          if (sram.gnt) begin
            state_nxt = READ;
            wait_load = 1'b1;
          end
        end
        READ: begin
          if (wait_cnt == '0) begin
            capture   = 1'b1;
            ptr_inc   = 1'b1;
            state_nxt = ARMED;
          end else begin
            wait_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request is gated combinationally so a stop/restart withdraws it in the same cycle.
  assign sram.req  = (state == REQ) && !i_stop && !i_start;
  assign sram.addr = rd_ptr;
  assign o_playing = (state != IDLE);
  assign o_state   = state;

`ifdef LOOP_MIX_EN
  logic signed [DATA_W-1:0] live_r;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     live_r <= '0;
    else if (i_valid) live_r <= i_live;
  end

  assign sample = sat_add(live_r, sram.rdata);
`else
  logic unused_live;
  assign unused_live = ^i_live;
  assign sample      = sram.rdata;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_r      <= '0;
      wait_cnt   <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_wrap     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_wrap     <= 1'b0;
      o_underrun <= i_valid && ((state == REQ) || (state == READ));
      if (len_load) len_r <= i_loop_len;
      if (wait_load)     wait_cnt <= WC_W'(READ_WAIT - 1);
      else if (wait_dec) wait_cnt <= wait_cnt - WC_W'(1);
      if (clear_data) begin
        o_data <= '0;
      end else if (capture) begin
        o_data  <= sample;
        o_valid <= 1'b1;
        o_wrap  <= ptr_wrap;
      end
`ifdef LOOP_MIX_EN
      else if ((state == IDLE) && i_valid) begin
        o_data  <= i_live;
        o_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_loop_sram_reader.sv
// Directed bench for loop_sram_reader: SRAM/arbiter model, sample scoreboard, summary line.
module tb_loop_sram_reader;
  import loop_pkg::*;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int READ_WAIT = 2;
`ifdef LOOP_MIX_EN
  localparam int IDLE_VALIDS = 2;
`else
  localparam int IDLE_VALIDS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic valid = 1'b0;
  logic [ADDR_W-1:0] loop_len = '0;
  logic signed [DATA_W-1:0] live = '0;
  logic signed [DATA_W-1:0] data;
  logic out_valid, playing, wrap, underrun;
  loop_state_t state;

  loop_sram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram ();

  loop_sram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_loop_len (loop_len),
    .i_valid    (valid),
    .i_live     (live),
    .sram       (sram),
    .o_data     (data),
    .o_valid    (out_valid),
    .o_playing  (playing),
    .o_wrap     (wrap),
    .o_underrun (underrun),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  // SRAM and arbiter model: grant after gnt_delay cycles of request, data valid exactly
  // READ_WAIT cycles after the grant cycle, filler otherwise.
  logic signed [DATA_W-1:0] mem [16];
  int gnt_delay = 0;
  int req_age = 0;
  int rd_cnt = 0;
  logic [ADDR_W-1:0] rd_addr = '0;

  always @(posedge clk) begin
    req_age <= sram.req ? req_age + 1 : 0;
    if (sram.req && sram.gnt) begin
      rd_cnt  <= READ_WAIT;
      rd_addr <= sram.addr;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign sram.gnt   = sram.req && (req_age >= gnt_delay);
  assign sram.rdata = (rd_cnt == 1) ? mem[rd_addr[3:0]] : 16'sh7eef;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each entry is {wrap, data} for the next o_valid pulse.
  logic [DATA_W:0] exp_q[$];
  logic [ADDR_W-1:0] fetch_log[$];
  int valid_cnt = 0, underrun_cnt = 0, stray_wrap = 0, req_cycles = 0, addr_glitch = 0;
  logic prev_req = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", {15'b0, wrap, data}, 32'hffff_ffff);
      else                   check("sample", {15'b0, wrap, data}, {15'b0, exp_q.pop_front()});
    end
    if (wrap && !out_valid) stray_wrap++;
    if (underrun) underrun_cnt++;
    if (sram.req) begin
      req_cycles++;
      if (prev_req && (sram.addr != prev_addr)) addr_glitch++;
      if (sram.gnt) fetch_log.push_back(sram.addr);
    end
    prev_req  = sram.req;
    prev_addr = sram.addr;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] len);
    start    = 1'b1;
    loop_len = len;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic strobe(input int gap);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(gap - 1);
  endtask

  task automatic push_exp(input logic signed [DATA_W-1:0] d, input logic w);
    exp_q.push_back({w, d});
  endtask

  int v0, r0, u0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 16'sd100;
    mem[1] = -16'sd200;
    mem[2] = 16'sd300;
    mem[3] = -16'sd400;

    tick(3);
    check("rst_data", data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_playing", playing, 0);
    check("rst_wrap", wrap, 0);
    check("rst_underrun", underrun, 0);
    check("rst_req", sram.req, 0);
    check("rst_state", state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Basic playback with exact latency on the first strobe.
    pulse_start(4);
    check("t1_playing", playing, 1);
    check("t1_state", state, ARMED);
    push_exp(100, 1'b0);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(2);
    check("t1_latency_early", out_valid, 0);
    tick(1);
    check("t1_latency", out_valid, 1);
    tick(4);
    push_exp(-200, 1'b0); strobe(8);
    push_exp(300, 1'b0);  strobe(8);
    push_exp(-400, 1'b1); strobe(8);
    push_exp(100, 1'b0);  strobe(8);
    push_exp(-200, 1'b0); strobe(8);
    check("t1_drain", exp_q.size(), 0);

    // Empty loop: start ignored.
    pulse_stop();
    v0 = valid_cnt;
    r0 = req_cycles;
    pulse_start(0);
    check("t2_playing", playing, 0);
    check("t2_state", state, IDLE);
`ifdef LOOP_MIX_EN
    push_exp(0, 1'b0);
    push_exp(0, 1'b0);
`endif
    strobe(8);
    strobe(8);
    check("t2_req", req_cycles - r0, 0);
    check("t2_valid", valid_cnt - v0, IDLE_VALIDS);

    // Grant withheld, second strobe during REQ.
    pulse_start(4);
    gnt_delay = 5;
    u0 = underrun_cnt;
    v0 = valid_cnt;
    push_exp(100, 1'b0);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(1);
    check("t3_state", state, REQ);
    check("t3_req", sram.req, 1);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(14);
    check("t3_underrun", underrun_cnt - u0, 1);
    check("t3_valid", valid_cnt - v0, 1);
    check("t3_addr_stable", addr_glitch, 0);
    check("t3_drain", exp_q.size(), 0);
    gnt_delay = 0;

    // Start and stop together during READ: stop wins, fetch discarded.
    pulse_start(4);
    v0 = valid_cnt;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(1);
    check("t4_state_read", state, READ);
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t4_state", state, IDLE);
    check("t4_req", sram.req, 0);
    check("t4_data", data, 0);
    check("t4_playing", playing, 0);
    tick(6);
    check("t4_valid", valid_cnt - v0, 0);

    // Stop withdraws a pending request in the same cycle.
    pulse_start(4);
    gnt_delay = 10;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("t5_req_before", sram.req, 1);
    stop = 1'b1;
    #1;
    check("t5_req_drop", sram.req, 0);
    tick(1);
    stop = 1'b0;
    check("t5_state", state, IDLE);
    gnt_delay = 0;

    // Restart mid-loop with a shorter length; later length changes ignored.
    pulse_start(4);
    push_exp(100, 1'b0);  strobe(8);
    push_exp(-200, 1'b0); strobe(8);
    fetch_log.delete();
    pulse_start(2);
    loop_len = 7;
    push_exp(100, 1'b0);  strobe(8);
    push_exp(-200, 1'b1); strobe(8);
    push_exp(100, 1'b0);  strobe(8);
    check("t6_fetches", fetch_log.size(), 3);
    if (fetch_log.size() == 3) begin
      check("t6_addr0", fetch_log[0], 0);
      check("t6_addr1", fetch_log[1], 1);
      check("t6_addr2", fetch_log[2], 0);
    end
    check("t6_drain", exp_q.size(), 0);

    // Single-sample loop wraps every time.
    pulse_start(1);
    push_exp(100, 1'b1); strobe(8);
    push_exp(100, 1'b1); strobe(8);
    check("t7_drain", exp_q.size(), 0);

    // Asynchronous reset during a pending request.
    gnt_delay = 10;
    v0 = valid_cnt;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("t8_req_before", sram.req, 1);
    rst_n = 1'b0;
    #1;
    check("t8_req_drop", sram.req, 0);
    check("t8_state", state, IDLE);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    tick(6);
    check("t8_valid", valid_cnt - v0, 0);

`ifdef LOOP_MIX_EN
    mem[0] = 16'sd10000;
    mem[1] = -16'sd10000;
    pulse_start(2);
    live = 16'sd30000;
    push_exp(32767, 1'b0);  strobe(8);
    live = -16'sd30000;
    push_exp(-32768, 1'b1); strobe(8);
    pulse_stop();
    live = 16'sd1234;
    push_exp(1234, 1'b0);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("mix_passthru_valid", out_valid, 1);
    check("mix_passthru_data", data, 1234);
    live = '0;
    tick(4);
`endif

    check("final_drain", exp_q.size(), 0);
    check("stray_wrap", stray_wrap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
